// File: rtl/vram_arbiter_if.sv
// ----------------------------------------------------------------------------
// vram_arbiter_if
// Bundles every signal of the VRAM arbiter except clock and reset.
//   Scanout side : disp_req, disp_addr -> disp_data, disp_valid
//   Host side    : host_valid, host_we, host_addr, host_wdata -> host_ready,
//                  host_rdata, host_rvalid
//   RAM side     : mem_addr, mem_we, mem_wdata (registered) <- mem_rdata
//   Status       : stat_clr -> host_starved, stat_wait
// Modports:
//   slave  - the arbiter (consumes requests, drives RAM and results)
//   master - the environment (scanout, host, RAM model)
// ----------------------------------------------------------------------------
interface vram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;

    logic              host_valid;
    logic              host_ready;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              host_starved;
    logic              stat_clr;
    logic [15:0]       stat_wait;

    modport slave (
        input  disp_req, disp_addr, host_valid, host_we, host_addr,
               host_wdata, mem_rdata, stat_clr,
        output disp_data, disp_valid, host_ready, host_rdata, host_rvalid,
               mem_addr, mem_we, mem_wdata, host_starved, stat_wait
    );

    modport master (
        output disp_req, disp_addr, host_valid, host_we, host_addr,
               host_wdata, mem_rdata, stat_clr,
        input  disp_data, disp_valid, host_ready, host_rdata, host_rvalid,
               mem_addr, mem_we, mem_wdata, host_starved, stat_wait
    );
endinterface

// File: rtl/vram_arbiter.sv
// ----------------------------------------------------------------------------
// vram_arbiter
// Shares one single-port synchronous video RAM between display scanout and a
// host port. Scanout always wins; the host is accepted only in cycles with no
// scanout request. Both read paths have a fixed 3-cycle latency:
//   N   : request sampled
//   N+1 : mem_addr/mem_we presented (registered)
//   N+2 : RAM returns mem_rdata
//   N+3 : disp_data/host_rdata registered with their valid
// A two-stage owner tag follows each RAM access so returned data lands on the
// correct port.
// Ports:
//   clk_pixel - pixel clock, all logic on rising edge
//   reset     - asynchronous active-high reset
//   bus       - vram_arbiter_if.slave (scanout, host, RAM and status signals)
// Parameters:
//   ADDR_W, DATA_W - RAM address/word widths (must match the interface)
//   STARVE_LIMIT   - host wait cycles before host_starved (1..255)
// ----------------------------------------------------------------------------
module vram_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 8
) (
    input logic           clk_pixel,
    input logic           reset,
    vram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_HOST = 2'd2
    } tag_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    // Registered state
    logic [ADDR_W-1:0] mem_addr_reg,   mem_addr_next;
    logic              mem_we_reg,     mem_we_next;
    logic [DATA_W-1:0] mem_wdata_reg,  mem_wdata_next;
    tag_t              tag_s1_reg,     tag_s1_next;
    tag_t              tag_s2_reg;
    logic [DATA_W-1:0] disp_data_reg,  disp_data_next;
    logic              disp_valid_reg, disp_valid_next;
    logic [DATA_W-1:0] host_rdata_reg, host_rdata_next;
    logic              host_rvalid_reg, host_rvalid_next;
    logic [7:0]        wait_cnt_reg,   wait_cnt_next;
    logic              starved_reg,    starved_next;
    logic [15:0]       stat_wait_reg,  stat_wait_next;

    logic host_accept;
    logic host_wait;

    // Display has absolute priority, so the host is ready exactly when the
    // scanout is idle. This stays combinational even during reset.
    assign bus.host_ready = !bus.disp_req;
    assign host_accept    = bus.host_valid && !bus.disp_req;
    assign host_wait      = bus.host_valid && bus.disp_req;

    // RAM request stage
    always_comb begin
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_we_next    = 1'b0;
        tag_s1_next    = TAG_NONE;
        if (bus.disp_req) begin
            mem_addr_next = bus.disp_addr;
            tag_s1_next   = TAG_DISP;
        end else if (host_accept) begin
            mem_addr_next = bus.host_addr;
            if (bus.host_we) begin
                mem_we_next    = 1'b1;
                mem_wdata_next = bus.host_wdata;
            end else begin
                tag_s1_next = TAG_HOST;
            end
        end
    end

    // Return routing: tag_s2 lines up with mem_rdata from the RAM. Data
    // registers only load for their own owner, so they hold otherwise.
    always_comb begin
        disp_data_next   = disp_data_reg;
        host_rdata_next  = host_rdata_reg;
        disp_valid_next  = 1'b0;
        host_rvalid_next = 1'b0;
        case (tag_s2_reg)
            TAG_DISP: begin
                disp_valid_next = 1'b1;
                disp_data_next  = bus.mem_rdata;
            end
            TAG_HOST: begin
                host_rvalid_next = 1'b1;
                host_rdata_next  = bus.mem_rdata;
            end
            default: ;
        endcase
    end

    // Starvation and statistics
    always_comb begin
        wait_cnt_next = 8'd0;
        if (host_wait) begin
            wait_cnt_next = (wait_cnt_reg == LIMIT) ? wait_cnt_reg
                                                    : wait_cnt_reg + 8'd1;
        end

        // Flag goes high the cycle after the counter sits at the limit while
        // the host is still waiting, and drops the cycle after the host is
        // accepted or withdraws.
        starved_next = host_wait && (wait_cnt_reg == LIMIT);

        stat_wait_next = stat_wait_reg;
        if (bus.stat_clr) begin
            stat_wait_next = 16'd0;
        end else if (host_wait && (stat_wait_reg != 16'hFFFF)) begin
            stat_wait_next = stat_wait_reg + 16'd1;
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            mem_addr_reg    <= '0;
            mem_we_reg      <= 1'b0;
            mem_wdata_reg   <= '0;
            tag_s1_reg      <= TAG_NONE;
            tag_s2_reg      <= TAG_NONE;
            disp_data_reg   <= '0;
            disp_valid_reg  <= 1'b0;
            host_rdata_reg  <= '0;
            host_rvalid_reg <= 1'b0;
            wait_cnt_reg    <= 8'd0;
            starved_reg     <= 1'b0;
            stat_wait_reg   <= 16'd0;
        end else begin
            mem_addr_reg    <= mem_addr_next;
            mem_we_reg      <= mem_we_next;
            mem_wdata_reg   <= mem_wdata_next;
            tag_s1_reg      <= tag_s1_next;
            tag_s2_reg      <= tag_s1_reg;
            disp_data_reg   <= disp_data_next;
            disp_valid_reg  <= disp_valid_next;
            host_rdata_reg  <= host_rdata_next;
            host_rvalid_reg <= host_rvalid_next;
            wait_cnt_reg    <= wait_cnt_next;
            starved_reg     <= starved_next;
            stat_wait_reg   <= stat_wait_next;
        end
    end

    assign bus.mem_addr     = mem_addr_reg;
    assign bus.mem_we       = mem_we_reg;
    assign bus.mem_wdata    = mem_wdata_reg;
    assign bus.disp_data    = disp_data_reg;
    assign bus.disp_valid   = disp_valid_reg;
    assign bus.host_rdata   = host_rdata_reg;
    assign bus.host_rvalid  = host_rvalid_reg;
    assign bus.host_starved = starved_reg;
    assign bus.stat_wait    = stat_wait_reg;

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, video memory address width in bits.
REQ-002 Parameter DATA_W, default 8, video memory word width in bits.
REQ-003 Parameter STARVE_LIMIT, default 8, host wait cycles before host_starved asserts; legal range 1..255.
REQ-004 clk_pixel  in  1  single clock; all logic rising-edge; pixel clock domain.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 disp_req  in  1  scanout needs one word this cycle.
REQ-007 disp_addr  in  ADDR_W  scanout word address, qualified by disp_req.
REQ-008 disp_data  out  DATA_W  scanout read data, qualified by disp_valid.
REQ-009 disp_valid  out  1  disp_data carries the word for an earlier disp_req.
REQ-010 host_valid  in  1  host access request.
REQ-011 host_ready  out  1  host request accepted this cycle.
REQ-012 host_we  in  1  1 = write, 0 = read; qualified by host_valid.
REQ-013 host_addr  in  ADDR_W  host word address.
REQ-014 host_wdata  in  DATA_W  host write data.
REQ-015 host_rdata  out  DATA_W  host read data, qualified by host_rvalid.
REQ-016 host_rvalid  out  1  host_rdata carries the word for an accepted host read.
REQ-017 mem_addr  out  ADDR_W  registered address to the single-port RAM.
REQ-018 mem_we  out  1  registered write strobe to the RAM.
REQ-019 mem_wdata  out  DATA_W  registered write data to the RAM.
REQ-020 mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_addr is presented.
REQ-021 host_starved  out  1  host waited STARVE_LIMIT or more consecutive cycles.
REQ-022 stat_clr  in  1  synchronous clear of stat_wait.
REQ-023 stat_wait  out  16  saturating count of host wait cycles.

Function
REQ-024 Display has absolute priority: host_ready SHALL be combinationally equal to !disp_req.
REQ-025 Handshake: a host transfer occurs in any cycle with host_valid && host_ready; the host holds host_we/addr/wdata stable while host_valid && !host_ready.
REQ-026 Cycle N with disp_req: mem_addr=disp_addr(N) and mem_we=0 in cycle N+1; disp_valid=1 with disp_data=mem_rdata(N+2) in cycle N+3. Fixed latency 3, no bubbles, back-to-back disp_req every cycle supported.
REQ-027 Host read accepted in cycle N: mem_addr=host_addr and mem_we=0 in N+1; host_rvalid=1 with host_rdata in N+3. Same latency as display.
REQ-028 Host write accepted in cycle N: mem_addr=host_addr, mem_wdata=host_wdata, mem_we=1 in N+1 only; no host_rvalid.
REQ-029 Cycle with no access: mem_we=0 next cycle; mem_addr and mem_wdata hold their previous values.
REQ-030 A 2-bit owner tag per pipeline stage (none/disp/host-read) SHALL route returned data; disp_valid and host_rvalid are never high in the same cycle.
REQ-031 disp_data and host_rdata SHALL hold their last values when their valid is low.
REQ-032 Wait counter: host_wait_cnt increments (saturating at STARVE_LIMIT) each cycle host_valid && !host_ready; clears on acceptance or when host_valid=0.
REQ-033 host_starved SHALL be registered: 1 from the cycle after host_wait_cnt reaches STARVE_LIMIT until the cycle after host acceptance or host_valid=0.
REQ-034 stat_wait increments by 1 each cycle host_valid && !host_ready; saturates at 16'hFFFF; stat_clr wins over a same-cycle increment (result 0).
REQ-035 Read-after-write to the same address in consecutive accepted cycles returns the new data (single-port RAM ordering).

Reset
REQ-036 reset asserted: mem_addr, mem_wdata, disp_data, host_rdata = 0; mem_we, disp_valid, host_rvalid, host_starved = 0; stat_wait = 0; all pipeline tags = none.
REQ-037 Reset during in-flight reads: discard them; no disp_valid or host_rvalid for requests issued before reset deassertion.
REQ-038 host_ready still follows !disp_req during reset; transfers during reset are ignored (no memory write, no read return).

Verification
REQ-039 disp_req=1 with addr 0x0010..0x0013 for 4 cycles, RAM preloaded with addr[7:0] -> disp_valid high 4 cycles starting 3 cycles later, data 0x10,0x11,0x12,0x13.
REQ-040 host_valid=1, we=1, addr 0x0100, wdata 0xA5, disp_req=0 -> host_ready=1 same cycle; mem_we=1 exactly one cycle; a later host read of 0x0100 gives host_rvalid with 0xA5 after 3 cycles.
REQ-041 host_valid held with disp_req=1 for 10 cycles, STARVE_LIMIT=8 -> host_ready=0 throughout; host_starved rises after 8 wait cycles; stat_wait=10; acceptance on the first disp_req=0 cycle clears host_starved the next cycle.
REQ-042 Interleaved disp_req/host read on alternate cycles -> each return is tagged correctly; disp_valid and host_rvalid never overlap.
REQ-043 reset pulsed one cycle after 2 disp_req reads -> no disp_valid afterward; all outputs 0 during reset.
REQ-044 stat_wait forced to 0xFFFF by 65540 wait cycles -> holds 0xFFFF; stat_clr during a wait cycle -> 0.
